// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl: moves OFIFO vectors into the PSUM SRAM (overwrite or saturating
// accumulate) and streams a ReLU readout of a PSUM address range.
module psum_accum_ctrl #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic [addr_bw-1:0]     len,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_out,
  output logic                   ofifo_rd,
  output logic                   pmem_cen,
  output logic                   pmem_wen,
  output logic [addr_bw-1:0]     pmem_a,
  output logic [col*psum_bw-1:0] pmem_d,
  input  logic [col*psum_bw-1:0] pmem_q,
  output logic                   out_valid,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   sat_flag
);

  localparam int unsigned VEC_BW = col * psum_bw;

  localparam logic [1:0] MODE_OVR = 2'b00;
  localparam logic [1:0] MODE_ACC = 2'b01;
  localparam logic [1:0] MODE_RO  = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OVR      = 3'd1,
    ACC_RD   = 3'd2,
    ACC_WR   = 3'd3,
    RO       = 3'd4,
    RO_DRAIN = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [addr_bw-1:0] addr_q;
  logic [addr_bw-1:0] len_q;
  logic [addr_bw-1:0] cnt_q;
  logic               last_c;
  logic               adv_c;
  logic [VEC_BW-1:0]  acc_sum_c;
  logic [VEC_BW-1:0]  relu_c;
  logic [col-1:0]     lane_sat_c;

  // Per-lane saturating add of SRAM read data and OFIFO head, plus ReLU of read data
  for (genvar l = 0; l < col; l++) begin : g_lane
    logic [psum_bw-1:0] q_l;
    logic [psum_bw-1:0] f_l;
    logic [psum_bw:0]   s_l;
    assign q_l = pmem_q[l*psum_bw +: psum_bw];
    assign f_l = ofifo_out[l*psum_bw +: psum_bw];
    assign s_l = {q_l[psum_bw-1], q_l} + {f_l[psum_bw-1], f_l};
    assign lane_sat_c[l] = s_l[psum_bw] ^ s_l[psum_bw-1];
    assign acc_sum_c[l*psum_bw +: psum_bw] = lane_sat_c[l]
                                           ? {s_l[psum_bw], {(psum_bw-1){~s_l[psum_bw]}}}
                                           : s_l[psum_bw-1:0];
    assign relu_c[l*psum_bw +: psum_bw] = q_l[psum_bw-1] ? '0 : q_l;
  end

  assign last_c = (addr_bw'(cnt_q + 1'b1) == len_q);
  // One vector retired (written or read out) this cycle
  assign adv_c  = ((state == OVR || state == ACC_WR) && ofifo_valid) || (state == RO);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)              state_nxt = DONE;
          else if (mode == MODE_OVR)  state_nxt = OVR;
          else if (mode == MODE_ACC)  state_nxt = ACC_RD;
          else if (mode == MODE_RO)   state_nxt = RO;
          else                        state_nxt = DONE;
        end
      end
      OVR:      if (ofifo_valid && last_c) state_nxt = DONE;
      ACC_RD:   if (ofifo_valid) state_nxt = ACC_WR;
      // Losing the head before the write falls back to a fresh read of the same address
      ACC_WR: begin
        if (!ofifo_valid) state_nxt = ACC_RD;
        else if (last_c)  state_nxt = DONE;
        else              state_nxt = ACC_RD;
      end
      RO:       if (last_c) state_nxt = RO_DRAIN;
      RO_DRAIN: state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ofifo_rd = 1'b0;
    pmem_cen = 1'b1;
    pmem_wen = 1'b1;
    pmem_a   = '0;
    pmem_d   = '0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      OVR: begin
        if (ofifo_valid) begin
          ofifo_rd = 1'b1;
          pmem_cen = 1'b0;
          pmem_wen = 1'b0;
          pmem_a   = addr_q;
          pmem_d   = ofifo_out;
        end
      end
      ACC_RD: begin
        if (ofifo_valid) begin
          pmem_cen = 1'b0;
          pmem_a   = addr_q;
        end
      end
      ACC_WR: begin
        if (ofifo_valid) begin
          ofifo_rd = 1'b1;
          pmem_cen = 1'b0;
          pmem_wen = 1'b0;
          pmem_a   = addr_q;
          pmem_d   = acc_sum_c;
        end
      end
      RO: begin
        pmem_cen = 1'b0;
        pmem_a   = addr_q;
      end
      default: ;
    endcase
  end

  // Pass parameters, vector counter, readout valid and sticky saturation
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= (state == RO);
      if (state == IDLE && start) begin
        addr_q   <= base_addr;
        len_q    <= len;
        cnt_q    <= '0;
        sat_flag <= 1'b0;
      end else begin
        if (adv_c) begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q + 1'b1;
        end
        if (state == ACC_WR && ofifo_valid && (|lane_sat_c)) sat_flag <= 1'b1;
      end
    end
  end

  assign out_data = out_valid ? relu_c : '0;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// tb_psum_accum_ctrl: directed and randomized passes checked against a
// transaction-level model of SRAM contents, OFIFO consumption and readout.
module tb_psum_accum_ctrl;

  localparam int unsigned COL   = 8;
  localparam int unsigned PBW   = 16;
  localparam int unsigned ABW   = 11;
  localparam int unsigned VW    = COL * PBW;
  localparam int          DEPTH = 1 << ABW;
  localparam int          FDEPTH = 4096;
  localparam int          PMAX  = (1 << (PBW - 1)) - 1;
  localparam int          PMIN  = -(1 << (PBW - 1));

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     mode;
  logic [ABW-1:0] base_addr;
  logic [ABW-1:0] len;
  logic           ofifo_valid;
  logic [VW-1:0]  ofifo_out;
  logic           ofifo_rd;
  logic           pmem_cen;
  logic           pmem_wen;
  logic [ABW-1:0] pmem_a;
  logic [VW-1:0]  pmem_d;
  logic [VW-1:0]  pmem_q;
  logic           out_valid;
  logic [VW-1:0]  out_data;
  logic           busy;
  logic           done;
  logic           sat_flag;

  always #5 clk = ~clk;

  psum_accum_ctrl #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr), .len(len),
    .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
    .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_a(pmem_a), .pmem_d(pmem_d), .pmem_q(pmem_q),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Environment: SRAM, OFIFO and event logs
  logic [VW-1:0]  mem     [DEPTH];
  logic [VW-1:0]  ref_mem [DEPTH];
  logic [VW-1:0]  fifo_mem [FDEPTH];
  int             wp = 0;
  int             rp = 0;
  logic           bd_we = 1'b0;
  logic [ABW-1:0] bd_a  = '0;
  logic [VW-1:0]  bd_d  = '0;
  logic [ABW-1:0] wr_addr_log[$];
  logic [VW-1:0]  wr_data_log[$];
  logic [ABW-1:0] rd_addr_log[$];
  logic [VW-1:0]  ro_log[$];
  int acc_count = 0;
  int rd_count = 0;
  int rd_viol = 0;
  int done_pulses = 0;
  int allow_pct = 100;
  logic [VW-1:0] preset[$];

  always @(posedge clk) begin
    if (bd_we) mem[bd_a] <= bd_d;
    else if (!pmem_cen) begin
      acc_count <= acc_count + 1;
      if (!pmem_wen) begin
        mem[pmem_a] <= pmem_d;
        wr_addr_log.push_back(pmem_a);
        wr_data_log.push_back(pmem_d);
      end else begin
        pmem_q <= mem[pmem_a];
        rd_addr_log.push_back(pmem_a);
      end
    end
    if (ofifo_rd) begin
      if (!ofifo_valid || rp == wp) rd_viol <= rd_viol + 1;
      else begin
        rp       <= rp + 1;
        rd_count <= rd_count + 1;
      end
    end
    if (out_valid) ro_log.push_back(out_data);
    if (done) done_pulses <= done_pulses + 1;
  end

  function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] x, input logic [VW-1:0] y,
                                            output bit s);
    logic [VW-1:0] r;
    int t;
    r = '0;
    s = 1'b0;
    for (int l = 0; l < COL; l++) begin
      t = int'($signed(x[l*PBW +: PBW])) + int'($signed(y[l*PBW +: PBW]));
      if (t > PMAX) begin t = PMAX; s = 1'b1; end
      else if (t < PMIN) begin t = PMIN; s = 1'b1; end
      r[l*PBW +: PBW] = PBW'(t);
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] relu(input logic [VW-1:0] x);
    logic [VW-1:0] r;
    r = '0;
    for (int l = 0; l < COL; l++)
      if (int'($signed(x[l*PBW +: PBW])) > 0) r[l*PBW +: PBW] = x[l*PBW +: PBW];
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int l = 0; l < COL; l++) begin
      if ($urandom_range(0, 1) == 0) v[l*PBW +: PBW] = PBW'($urandom);
      else v[l*PBW +: PBW] = PBW'($urandom_range(0, 4000) - 2000);
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] splat(input int x);
    logic [VW-1:0] v;
    v = '0;
    for (int l = 0; l < COL; l++) v[l*PBW +: PBW] = PBW'(x);
    return v;
  endfunction

  // Advance to the next falling edge, present the OFIFO head, then settle
  task automatic step();
    @(negedge clk);
    ofifo_valid = (wp != rp) && ($urandom_range(0, 99) < allow_pct);
    ofifo_out   = (wp != rp) ? fifo_mem[rp % FDEPTH] : '0;
    #1;
  endtask

  task automatic preload(input int a, input logic [VW-1:0] v);
    step();
    bd_we = 1'b1; bd_a = ABW'(a); bd_d = v; ref_mem[a] = v;
    step();
    bd_we = 1'b0;
  endtask

  task automatic run_pass(input logic [1:0] m, input int b, input int n, input bit poke,
                          input bit exact);
    logic [VW-1:0] vin[$];
    int            exp_wa[$];
    logic [VW-1:0] exp_wd[$];
    int            exp_ra[$];
    logic [VW-1:0] exp_ro[$];
    logic [VW-1:0] r;
    bit exp_sat, s, got;
    int a, cyc, explat, w0, r0, ro0, d0, a0, p0, v0;
    exp_sat = 1'b0;
    if (n > 0 && (m == 2'b00 || m == 2'b01)) begin
      for (int i = 0; i < n; i++) begin
        r = (preset.size() > 0) ? preset.pop_front() : rand_vec();
        vin.push_back(r);
        fifo_mem[wp % FDEPTH] = r;
        wp++;
      end
    end
    for (int i = 0; i < n; i++) begin
      a = (b + i) % DEPTH;
      case (m)
        2'b00: begin exp_wa.push_back(a); exp_wd.push_back(vin[i]); ref_mem[a] = vin[i]; end
        2'b01: begin
          r = sat_add(ref_mem[a], vin[i], s);
          exp_sat = exp_sat | s;
          exp_wa.push_back(a); exp_wd.push_back(r); ref_mem[a] = r;
        end
        2'b10: begin exp_ra.push_back(a); exp_ro.push_back(relu(ref_mem[a])); end
        default: ;
      endcase
    end
    if (n == 0 || m == 2'b11) explat = 1;
    else if (m == 2'b00)      explat = n + 1;
    else if (m == 2'b01)      explat = 2 * n + 1;
    else                      explat = n + 2;
    w0 = wr_addr_log.size(); r0 = rd_addr_log.size(); ro0 = ro_log.size();
    d0 = done_pulses; a0 = acc_count; p0 = rd_count; v0 = rd_viol;

    step();
    start = 1'b1; mode = m; base_addr = ABW'(b); len = ABW'(n);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 1000) begin
      step();
      cyc++;
      start = 1'b0;
      if (done) got = 1'b1;
      else if (poke && cyc == 2) begin start = 1'b1; mode = 2'b11; len = '0; end
    end
    step();
    start = 1'b0;

    check("done_seen", VW'(got), VW'(1));
    if (exact) check("latency", VW'(cyc), VW'(explat));
    check("idle_after", VW'({busy, done}), VW'(0));
    check("done_pulses", VW'(done_pulses - d0), VW'(1));
    check("wr_count", VW'(wr_addr_log.size() - w0), VW'(exp_wa.size()));
    for (int i = 0; i < exp_wa.size() && w0 + i < wr_addr_log.size(); i++) begin
      check("wr_addr", VW'(wr_addr_log[w0 + i]), VW'(exp_wa[i]));
      check("wr_data", wr_data_log[w0 + i], exp_wd[i]);
    end
    check("pops", VW'(rd_count - p0), VW'(vin.size()));
    check("ro_beats", VW'(ro_log.size() - ro0), VW'(exp_ro.size()));
    for (int i = 0; i < exp_ro.size() && ro0 + i < ro_log.size(); i++)
      check("ro_data", ro_log[ro0 + i], exp_ro[i]);
    if (exact) begin
      check("accesses", VW'(acc_count - a0),
            VW'((m == 2'b01) ? 2 * exp_wa.size() : exp_wa.size() + exp_ra.size()));
      for (int i = 0; i < exp_ra.size() && r0 + i < rd_addr_log.size(); i++)
        check("rd_addr", VW'(rd_addr_log[r0 + i]), VW'(exp_ra[i]));
    end
    check("sat_flag", VW'(sat_flag), VW'(exp_sat));
    check("rd_without_valid", VW'(rd_viol - v0), VW'(0));
  endtask

  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] ev[5];
    logic [1:0]    rm;
    bit            s;
    int            k, nw, w0, d0;
    reset = 1'b0; start = 1'b0; mode = 2'b00; base_addr = '0; len = '0;
    ofifo_valid = 1'b0; ofifo_out = '0;

    // Fill SRAM with random contents while the block is held in reset
    for (int i = 0; i < DEPTH; i++) begin
      step();
      bd_we = 1'b1; bd_a = ABW'(i); bd_d = rand_vec(); ref_mem[i] = bd_d;
    end
    step();
    bd_we = 1'b0;
    check("rst_busy", VW'(busy), VW'(0));
    check("rst_done", VW'(done), VW'(0));
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_sat", VW'(sat_flag), VW'(0));
    check("rst_ofifo_rd", VW'(ofifo_rd), VW'(0));
    check("rst_cen_wen", VW'({pmem_cen, pmem_wen}), VW'(3));
    check("rst_pmem_a", VW'(pmem_a), VW'(0));
    check("rst_pmem_d", pmem_d, '0);
    check("rst_out_data", out_data, '0);
    reset = 1'b1;

    allow_pct = 100;
    run_pass(2'b00, 5, 3, 1'b1, 1'b1);

    preload(10, splat(100));
    preset.push_back(splat(23));
    run_pass(2'b01, 10, 1, 1'b0, 1'b1);
    check("acc_sram10", mem[10], splat(123));

    v = '0; v[15:0] = 16'd32000; preload(20, v);
    v = '0; v[15:0] = 16'd1000;  preset.push_back(v);
    run_pass(2'b01, 20, 1, 1'b0, 1'b1);
    v = mem[20];
    check("sat_lane0", VW'(v[15:0]), VW'(16'h7fff));
    step();
    check("sat_sticky", VW'(sat_flag), VW'(1));
    run_pass(2'b00, 30, 1, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      v = rand_vec(); v[15:0] = 16'hfffb; v[31:16] = 16'd7;
      preload((2046 + i) % DEPTH, v);
    end
    run_pass(2'b10, 2046, 4, 1'b0, 1'b1);
    v = ro_log[ro_log.size() - 4];
    check("ro_lanes01", VW'(v[31:0]), VW'(32'h0007_0000));

    run_pass(2'b00, 100, 0, 1'b0, 1'b1);
    run_pass(2'b11, 100, 5, 1'b0, 1'b1);

    allow_pct = 50;
    run_pass(2'b01, 200, 6, 1'b1, 1'b0);

    // Reset in the middle of an accumulate pass
    allow_pct = 100;
    for (int i = 0; i < 5; i++) begin
      v = rand_vec();
      fifo_mem[wp % FDEPTH] = v;
      wp++;
      ev[i] = sat_add(ref_mem[300 + i], v, s);
    end
    w0 = wr_addr_log.size(); d0 = done_pulses;
    step();
    start = 1'b1; mode = 2'b01; base_addr = ABW'(300); len = ABW'(5);
    step(); start = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    step();
    check("abort_busy", VW'(busy), VW'(0));
    check("abort_cen", VW'(pmem_cen), VW'(1));
    check("abort_out_valid", VW'(out_valid), VW'(0));
    repeat (2) begin
      step();
      check("abort_hold_cen", VW'(pmem_cen), VW'(1));
    end
    reset = 1'b1;
    repeat (3) begin
      step();
      check("abort_idle", VW'({busy, done, pmem_cen}), VW'(1));
    end
    check("abort_no_done", VW'(done_pulses - d0), VW'(0));
    nw = wr_addr_log.size() - w0;
    check("abort_partial", VW'(nw > 0 && nw < 5), VW'(1));
    for (int i = 0; i < nw && i < 5; i++) begin
      check("abort_wr_addr", VW'(wr_addr_log[w0 + i]), VW'(300 + i));
      check("abort_wr_data", wr_data_log[w0 + i], ev[i]);
      ref_mem[300 + i] = ev[i];
    end
    wp = rp;

    repeat (24) begin
      rm = 2'($urandom_range(0, 3));
      k = $urandom_range(0, 2);
      allow_pct = (k == 0) ? 100 : ((k == 1) ? 60 : 35);
      run_pass(rm, $urandom_range(0, DEPTH - 1), $urandom_range(0, 12),
               1'($urandom_range(0, 1)), allow_pct == 100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_accum_ctrl.md
PSUM_ACCUM_CTRL -- requirements
Module: psum_accum_ctrl

Interface
REQ-001 Parameter col, default 8, number of output columns (lanes per vector).
REQ-002 Parameter psum_bw, default 16, signed partial-sum width per lane.
REQ-003 Parameter addr_bw, default 11, PSUM SRAM address width.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-low; reset=0 at a posedge resets the block.
REQ-006 start  in  1  begins a pass when sampled high in IDLE.
REQ-007 mode  in  2  pass type: 00 overwrite, 01 accumulate, 10 ReLU readout, 11 reserved.
REQ-008 base_addr  in  addr_bw  first PSUM address of the pass.
REQ-009 len  in  addr_bw  number of vectors in the pass.
REQ-010 ofifo_valid  in  1  OFIFO holds at least one vector.
REQ-011 ofifo_out  in  col*psum_bw  OFIFO head vector, valid in the cycle ofifo_rd is high (show-ahead).
REQ-012 ofifo_rd  out  1  pops the OFIFO head.
REQ-013 pmem_cen / pmem_wen  out  1 each  SRAM chip enable and write enable, both active-low.
REQ-014 pmem_a  out  addr_bw  SRAM address.
REQ-015 pmem_d  out  col*psum_bw  SRAM write data.
REQ-016 pmem_q  in  col*psum_bw  SRAM read data, valid one cycle after a read is issued.
REQ-017 out_valid / out_data  out  1 / col*psum_bw  readout stream.
REQ-018 busy, done, sat_flag  out  1 each  pass active; one-cycle completion pulse; sticky saturation indicator.

Function
REQ-019 start, mode, base_addr and len shall be captured on the accepted start edge; start shall be ignored while busy=1.
REQ-020 States: IDLE, OVR, ACC_RD, ACC_WR, RO, RO_DRAIN, DONE; DONE shall last one cycle with done=1 and then return to IDLE.
REQ-021 busy shall be 1 in every state except IDLE.
REQ-022 The address for vector i shall be (base_addr+i) mod 2^addr_bw, wrapping silently.
REQ-023 A pass with len=0, or with mode=11, shall go directly to DONE (done one cycle after start) with no SRAM access and no ofifo_rd.
REQ-024 OVR: in each cycle with ofifo_valid=1, ofifo_rd=1, cen=0, wen=0, and ofifo_out shall be written to the current address, for a throughput of 1 vector/cycle; with ofifo_valid=0 the block shall stall with cen=1.
REQ-025 ACC_RD: entered or held only while ofifo_valid=1; it shall issue a read (cen=0, wen=1) at the current address; with ofifo_valid=0 it shall stall with cen=1.
REQ-026 ACC_WR: ofifo_rd=1, cen=0, wen=0 at the same address, with pmem_d = lane-wise sat(pmem_q + ofifo_out); 2 cycles per vector.
REQ-027 ofifo_rd shall be a combinational function of state and ofifo_valid only; ofifo_rd=1 with ofifo_valid=0 shall never occur.
REQ-028 Addition shall be per-lane two's-complement; overflow shall clamp to +(2^(psum_bw-1)-1) or -2^(psum_bw-1) and set sat_flag.
REQ-029 sat_flag shall be sticky until reset or the next accepted start.
REQ-030 RO: reads at consecutive addresses, one per cycle, for len cycles; RO_DRAIN shall last one cycle.
REQ-031 out_valid shall be 1 in the cycle after each read, with out_data = lane-wise max(pmem_q, 0).
REQ-032 The readout stream shall have no backpressure and shall produce exactly len beats.
REQ-033 The pass shall transition to DONE in the cycle after the last write (OVR, ACC) or the last out_valid beat (RO).
REQ-034 When not reading or writing: cen=1, wen=1, pmem_d=0, out_data=0.

Reset
REQ-035 When reset=0 at a posedge: state shall go to IDLE; busy, done, out_valid, ofifo_rd and sat_flag shall be 0; cen=1, wen=1.
REQ-036 Under reset, pmem_a, pmem_d and out_data shall be 0 and captured pass parameters shall be cleared.
REQ-037 Reset asserted mid-pass shall abort the pass at that edge with no further SRAM access and no done pulse.

Verification (col=8, psum_bw=16)
REQ-038 Overwrite: base=5, len=3, OFIFO pre-filled with vectors A,B,C -> writes at addresses 5,6,7 on 3 consecutive cycles; done 1 cycle later.
REQ-039 Accumulate: SRAM[10]=all lanes 100, OFIFO vector all lanes 23, len=1 -> SRAM[10]=all lanes 123; 2 busy cycles plus DONE.
REQ-040 Saturation: SRAM lane0=32000, OFIFO lane0=1000 -> lane0=32767, sat_flag=1; a subsequent start clears sat_flag.
REQ-041 Readout/wrap: base=2046, len=4, lanes {-5,7,...} -> reads at 2046,2047,0,1; out_data lanes {0,7,...}; 4 out_valid beats.
REQ-042 Stall/abort: ofifo_valid toggles 1,0,1 during an accumulate pass -> no ofifo_rd while it is 0 and no duplicate writes; reset=0 mid-pass -> IDLE with cen=1 and no done pulse.
REQ-043 Edge cases: len=0 and mode=11 -> done one cycle after start with no SRAM activity.
